// File: rtl/crc8_stream_rx.sv
// Byte-serial CRC-8 codeword receiver: 8 data bytes + CRC byte in, 64-bit checked word out.
// Optional CRC8_RX_DROP_BAD_EN: discard words with a non-zero residue and tie out_error low.
module crc8_stream_rx #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_error,
    output logic        trunc
);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t      state, state_nx;
    logic [3:0]  byte_cnt, cnt_nx, cnt_base;
    logic [7:0]  crc, crc_nx, crc_upd;
    logic [63:0] shreg, shreg_nx, od_nx;
    logic        ov_nx, oe_nx, trunc_nx;
    logic        accept, restart, complete, bad;

    function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int unsigned i = 0; i < 8; i++)
            r = r[7] ? ({r[6:0], 1'b0} ^ POLY) : {r[6:0], 1'b0};
        return r;
    endfunction

    assign in_ready = ~out_valid | out_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = byte_cnt;
        crc_nx   = crc;
        shreg_nx = shreg;
        ov_nx    = out_valid;
        od_nx    = out_data;
        oe_nx    = out_error;

        accept   = in_valid & in_ready;
        // An in_sof mid-frame restarts the count and CRC from this byte
        restart  = accept & in_sof & (byte_cnt != 4'd0);
        cnt_base = restart ? 4'd0 : byte_cnt;
        crc_upd  = crc_byte(restart ? INIT : crc, in_data);
        complete = accept & (cnt_base == 4'd8);
        bad      = (crc_upd != 8'h00);
        trunc_nx = restart;

        if (out_ready)
            ov_nx = 1'b0;

        if (accept) begin
            if (complete) begin
                state_nx = IDLE;
                cnt_nx   = '0;
                crc_nx   = INIT;
`ifdef CRC8_RX_DROP_BAD_EN
                oe_nx = 1'b0;
                if (!bad) begin
                    ov_nx = 1'b1;
                    od_nx = shreg;
                end
`else
                ov_nx = 1'b1;
                od_nx = shreg;
                oe_nx = bad;
`endif
            end else begin
                state_nx = COLLECT;
                cnt_nx   = cnt_base + 4'd1;
                crc_nx   = crc_upd;
                shreg_nx = {shreg[55:0], in_data};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            crc       <= INIT;
            shreg     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_error <= 1'b0;
            trunc     <= 1'b0;
        end else begin
            state     <= state_nx;
            byte_cnt  <= cnt_nx;
            crc       <= crc_nx;
            shreg     <= shreg_nx;
            out_valid <= ov_nx;
            out_data  <= od_nx;
            out_error <= oe_nx;
            trunc     <= trunc_nx;
        end
    end

endmodule

// File: tb/tb_crc8_stream_rx.sv
// Self-checking bench for crc8_stream_rx: frame-level reference model plus directed and random traffic.
module tb_crc8_stream_rx;

    localparam logic [7:0] POLY_TB = 8'h07;
`ifdef CRC8_RX_DROP_BAD_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_sof = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_error;
    logic        trunc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0]  tx_q[$];
    logic [64:0] dut_words[$];
    bit          rand_mode = 1'b0;
    bit          drv_acc = 1'b0;
    int          trunc_seen = 0;

    bit          model_on = 1'b0;
    logic [7:0]  frame[$];
    logic        exp_ov = 1'b0, exp_oe = 1'b0, exp_tr = 1'b0;
    logic [63:0] exp_od = '0;
    logic        m_acc, m_bad;
    logic [63:0] m_d;

    crc8_stream_rx #(.POLY(8'h07), .INIT(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_error(out_error), .trunc(trunc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Polynomial long division of the whole 72-bit codeword
    function automatic logic [7:0] residue(input logic [71:0] m);
        logic [71:0] r;
        r = m;
        for (int i = 71; i >= 8; i--)
            if (r[i]) r[i -: 9] = r[i -: 9] ^ {1'b1, POLY_TB};
        return r[7:0];
    endfunction

    function automatic logic [7:0] crc_of(input logic [63:0] d);
        return residue({d, 8'h00});
    endfunction

    // Reference model and per-cycle compare
    always @(negedge clk) begin
        if (model_on) begin
            check("in_ready", in_ready, !exp_ov || out_ready);
            check("out_valid", out_valid, exp_ov);
            check("out_data", out_data, exp_od);
            check("out_error", out_error, exp_oe);
            check("trunc", trunc, exp_tr);
        end
        if (out_valid === 1'b1 && out_ready) dut_words.push_back({out_error, out_data});
        if (trunc === 1'b1) trunc_seen++;

        if (!rst_n) begin
            frame.delete();
            exp_ov = 1'b0; exp_od = '0; exp_oe = 1'b0; exp_tr = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            m_acc  = in_valid && (!exp_ov || out_ready);
            exp_tr = 1'b0;
            if (out_ready) exp_ov = 1'b0;
            if (m_acc) begin
                if (in_sof && frame.size() != 0) begin
                    exp_tr = 1'b1;
                    frame.delete();
                end
                frame.push_back(in_data);
                if (frame.size() == 9) begin
                    m_d = '0;
                    for (int i = 0; i < 8; i++) m_d = {m_d[55:0], frame[i]};
                    m_bad = (residue({m_d, frame[8]}) != 8'h00);
                    if (!(DROP && m_bad)) begin
                        exp_ov = 1'b1;
                        exp_od = m_d;
                        exp_oe = m_bad;
                    end
                    frame.delete();
                end
            end
        end
    end

    always @(negedge clk) drv_acc = in_valid && in_ready && rst_n;

    // Byte driver: presents tx_q head, pops on handshake
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (drv_acc && tx_q.size() > 0) void'(tx_q.pop_front());
            if (rand_mode) out_ready = ($urandom_range(0, 9) < 7);
            if (tx_q.size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                {in_sof, in_data} = tx_q[0];
            end else begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
            end
        end
    end

    task automatic push_frame(input logic [63:0] d, input logic [7:0] c, input bit sof);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = d[63 - 8*i -: 8];
            tx_q.push_back({sof && (i == 0), b});
        end
        tx_q.push_back({1'b0, c});
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || in_valid) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            n_checks++;
            $display("FAIL %s: timeout after %0d cycles, %0d bytes pending, expected 0", name, n, tx_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base, tbase, nbad, n;
        logic [63:0] da, db, dr;
        logic [7:0]  cr;
        logic [64:0] w;

        check("pin_res_good", residue({64'hFFFF_FFFF_FFFF_FFFF, 8'hD7}), 64'h0);
        check("pin_res_bad",  residue({64'hFFFF_FFFF_FFFF_FFFF, 8'hD6}), 64'h1);
        check("pin_crc_ff",   crc_of(64'hFFFF_FFFF_FFFF_FFFF), 64'hD7);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);

        // Clean all-ones frame
        base = dut_words.size();
        push_frame(64'hFFFF_FFFF_FFFF_FFFF, 8'hD7, 1'b1);
        wait_idle("t1_idle", 200);
        check("t1_count", dut_words.size() - base, 1);
        w = dut_words[$];
        check("t1_word", w[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_err", w[64], 1'b0);

        // Zero frame then a corrupted frame
        base = dut_words.size();
        push_frame(64'h0, 8'h00, 1'b0);
        push_frame(64'hFFFF_FFFF_FFFF_FFFF, 8'hD6, 1'b0);
        wait_idle("t2_idle", 200);
        check("t2_count", dut_words.size() - base, DROP ? 1 : 2);
        w = dut_words[base];
        check("t2_zero_word", w, 65'h0);
        if (!DROP) begin
            w = dut_words[$];
            check("t2_bad_word", w, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        end

        // Backpressure across two back-to-back frames
        base = dut_words.size();
        da = 64'h0102_0304_0506_0708;
        db = 64'h1112_1314_1516_1718;
        @(posedge clk);
        #1 out_ready = 1'b0;
        push_frame(da, crc_of(da), 1'b1);
        push_frame(db, crc_of(db), 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_first_valid", out_valid, 1'b1);
        repeat (20) @(negedge clk);
        check("t3_in_ready_low", in_ready, 1'b0);
        check("t3_held_word", out_data, da);
        check("t3_pending", tx_q.size(), 9);
        check("t3_none_taken", dut_words.size() - base, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle("t3_idle", 200);
        check("t3_count", dut_words.size() - base, 2);
        check("t3_word_a", dut_words[base], {1'b0, da});
        check("t3_word_b", dut_words[base + 1], {1'b0, db});

        // in_sof on byte 5 truncates the partial frame
        base = dut_words.size();
        tbase = trunc_seen;
        for (int i = 0; i < 4; i++) tx_q.push_back({i == 0, 8'hAA});
        push_frame(64'hFFFF_FFFF_FFFF_FFFF, 8'hD7, 1'b1);
        wait_idle("t4_idle", 200);
        check("t4_trunc", trunc_seen - tbase, 1);
        check("t4_count", dut_words.size() - base, 1);
        check("t4_word", dut_words[$], {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});

        // Reset mid-frame
        base = dut_words.size();
        tbase = trunc_seen;
        for (int i = 0; i < 4; i++) tx_q.push_back({1'b0, 8'h55});
        wait_idle("t5_partial", 100);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_frame(64'hFFFF_FFFF_FFFF_FFFF, 8'hD7, 1'b0);
        wait_idle("t5_idle", 200);
        check("t5_count", dut_words.size() - base, 1);
        check("t5_word", dut_words[$], {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        check("t5_trunc", trunc_seen - tbase, 0);

        // Random gaps and backpressure, ~10% corrupted CRC
        base = dut_words.size();
        tbase = trunc_seen;
        nbad = 0;
        for (int f = 0; f < 1000; f++) begin
            dr = {$urandom(), $urandom()};
            cr = crc_of(dr);
            if ($urandom_range(0, 9) == 0) begin
                cr = cr ^ 8'($urandom_range(1, 255));
                nbad++;
            end
            push_frame(dr, cr, $urandom_range(0, 1) == 1);
        end
        rand_mode = 1'b1;
        wait_idle("t6_idle", 60000);
        @(posedge clk);
        #1 rand_mode = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_count", dut_words.size() - base, DROP ? 1000 - nbad : 1000);
        check("t6_trunc", trunc_seen - tbase, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
